// File: rtl/flobuffer_sched_if.sv
// Purpose: handshake/payload bundle between the decoder side and flobuffer_sched.
// master: drives queue/direct/pause/flush inputs, observes strobe and status.
// slave : the scheduler itself.
interface flobuffer_sched_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DELAY_W = 7,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned OVF_W   = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0]  data_i;
  logic [DELAY_W-1:0] delay_i;
  logic               valid_i;
  logic               direct_i;
  logic               pause_i;
  logic               flush_i;
  logic [DATA_W-1:0]  data_o;
  logic               stb_o;
  logic               empty_o;
  logic               full_o;
  logic [LVL_W-1:0]   level_o;
  logic               err_o;
  logic [OVF_W-1:0]   ovf_cnt_o;

  modport master (
    output data_i, delay_i, valid_i, direct_i, pause_i, flush_i,
    input  data_o, stb_o, empty_o, full_o, level_o, err_o, ovf_cnt_o
  );

  modport slave (
    input  data_i, delay_i, valid_i, direct_i, pause_i, flush_i,
    output data_o, stb_o, empty_o, full_o, level_o, err_o, ovf_cnt_o
  );
endinterface

// File: rtl/flobuffer_sched.sv
// Purpose: timed output buffer. Queues {delay,data} words in a FIFO and replays
// them as single-cycle strobes, each spaced by its delay after the previous one.
// Ports: clk, rst (async active-high), bus (flobuffer_sched_if.slave):
//   data_i/delay_i/valid_i push, direct_i pass-through, pause_i, flush_i;
//   data_o/stb_o output strobe, empty_o/full_o/level_o fill status,
//   err_o rejected-push pulse, ovf_cnt_o saturating reject count.
module flobuffer_sched #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DELAY_W = 7,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned OVF_W   = 8
) (
  input logic               clk,
  input logic               rst,
  flobuffer_sched_if.slave  bus
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LW     = AW + 1;
  localparam int unsigned WORD_W = DELAY_W + DATA_W;

  logic [WORD_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LW-1:0]      r_count;
  logic               r_loaded;
  logic [DELAY_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_word;
  logic [DATA_W-1:0]  r_data_o;
  logic               r_stb;
  logic               r_empty;
  logic               r_full;
  logic               r_err;
  logic [OVF_W-1:0]   r_ovf;

  logic [WORD_W-1:0]  w_head;
  logic               w_run;
  logic               w_emit;
  logic               w_pop;
  logic               w_push;
  logic               w_reject;
  logic [LW-1:0]      w_count_nxt;
  logic               w_loaded_nxt;

  // Read/write decisions for this edge; direct pass-through pre-empts a due word.
  always_comb begin
    w_head       = r_mem[r_rd_ptr];
    w_run        = !bus.pause_i && !bus.flush_i;
    w_emit       = w_run && r_loaded && (r_cnt == '0) && !bus.direct_i;
    // Loader only sees entries present before this edge (r_count), so a push
    // into an empty FIFO is picked up one edge later.
    w_pop        = w_run && (r_count != '0) && (!r_loaded || w_emit);
    w_push       = bus.valid_i && !bus.flush_i && (r_count != LW'(DEPTH));
    // Full check ignores a same-edge pop: the push is rejected regardless.
    w_reject     = bus.valid_i && !bus.flush_i && (r_count == LW'(DEPTH));
    w_count_nxt  = r_count + LW'(w_push) - LW'(w_pop);
    w_loaded_nxt = r_loaded;
    if (w_pop) begin
      w_loaded_nxt = 1'b1;
    end else if (w_emit) begin
      w_loaded_nxt = 1'b0;
    end
    if (bus.flush_i) begin
      w_count_nxt  = '0;
      w_loaded_nxt = 1'b0;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.delay_i, bus.data_i};
    end
  end

  // Pointers, loaded word, countdown and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_loaded <= 1'b0;
      r_cnt    <= '0;
      r_word   <= '0;
      r_data_o <= '0;
      r_stb    <= 1'b0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
      r_ovf    <= '0;
    end else begin
      r_count  <= w_count_nxt;
      r_loaded <= w_loaded_nxt;
      r_empty  <= (w_count_nxt == '0) && !w_loaded_nxt;
      r_full   <= (w_count_nxt == LW'(DEPTH));
      r_err    <= w_reject;
      if (w_reject && (r_ovf != '1)) begin
        r_ovf <= r_ovf + OVF_W'(1);
      end

      if (bus.flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      if (w_pop) begin
        r_word <= w_head[DATA_W-1:0];
        r_cnt  <= w_head[WORD_W-1:DATA_W];
      end else if (w_run && r_loaded && (r_cnt != '0)) begin
        r_cnt <= r_cnt - DELAY_W'(1);
      end

      r_stb <= 1'b0;
      if (bus.direct_i) begin
        r_data_o <= bus.data_i;
        r_stb    <= 1'b1;
      end else if (w_emit) begin
        r_data_o <= r_word;
        r_stb    <= 1'b1;
      end
    end
  end

  assign bus.data_o    = r_data_o;
  assign bus.stb_o     = r_stb;
  assign bus.empty_o   = r_empty;
  assign bus.full_o    = r_full;
  assign bus.level_o   = r_count;
  assign bus.err_o     = r_err;
  assign bus.ovf_cnt_o = r_ovf;
endmodule

// File: tb/tb_flobuffer_sched.sv
// Scoreboard bench: stimulus pushes expected {edge,data} strobes into queues,
// a negedge monitor pops and checks every strobe the DUT presents.
module tb_flobuffer_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_edge[$];
  logic [15:0] exp_data[$];
  int   m_e;
  logic [15:0] m_d;
  int   e0;

  flobuffer_sched_if #(.DATA_W(16), .DELAY_W(7), .DEPTH(4), .OVF_W(8)) bif ();

  flobuffer_sched #(.DATA_W(16), .DELAY_W(7), .DEPTH(4), .OVF_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expectation, edge and data.
  always @(negedge clk) begin
    if (!rst && bif.stb_o) begin
      total++;
      if (exp_edge.size() == 0) begin
        bad++;
        $display("FAIL unexpected_stb: edge=%0d data=%0h, none expected", cyc, bif.data_o);
      end else begin
        m_e = exp_edge.pop_front();
        m_d = exp_data.pop_front();
        if (m_e != cyc || m_d !== bif.data_o) begin
          bad++;
          $display("FAIL stb_check: got edge=%0d data=%0h, want edge=%0d data=%0h",
                   cyc, bif.data_o, m_e, m_d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic expect_stb(input int edge_n, input logic [15:0] d);
    exp_edge.push_back(edge_n);
    exp_data.push_back(d);
  endtask

  task automatic set_push(input logic [6:0] d, input logic [15:0] v);
    bif.valid_i = 1'b1;
    bif.delay_i = d;
    bif.data_i  = v;
  endtask

  task automatic idle_inputs();
    bif.valid_i  = 1'b0;
    bif.direct_i = 1'b0;
    bif.pause_i  = 1'b0;
    bif.flush_i  = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bif.data_i  = '0;
    bif.delay_i = '0;

    // Reset state
    repeat (3) step();
    chk("rst_data", 32'(bif.data_o), 32'h0);
    chk("rst_stb", 32'(bif.stb_o), 32'h0);
    chk("rst_empty", 32'(bif.empty_o), 32'h1);
    chk("rst_full", 32'(bif.full_o), 32'h0);
    chk("rst_level", 32'(bif.level_o), 32'h0);
    chk("rst_err", 32'(bif.err_o), 32'h0);
    chk("rst_ovf", 32'(bif.ovf_cnt_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single word d=3: strobe at push edge + 5
    set_push(7'd3, 16'h1234);
    step();
    e0 = cyc;
    idle_inputs();
    expect_stb(e0 + 5, 16'h1234);
    chk("t1_level", 32'(bif.level_o), 32'h1);
    chk("t1_empty_busy", 32'(bif.empty_o), 32'h0);
    wait_until(e0 + 8);
    chk("t1_empty_after", 32'(bif.empty_o), 32'h1);
    chk("t1_level_after", 32'(bif.level_o), 32'h0);

    // Four d=0 words: back-to-back strobes starting at first push + 2
    for (int i = 0; i < 4; i++) begin
      set_push(7'd0, 16'h00A0 + 16'(i));
      step();
      if (i == 0) e0 = cyc;
      expect_stb(e0 + 2 + i, 16'h00A0 + 16'(i));
      chk("t2_not_full", 32'(bif.full_o), 32'h0);
    end
    idle_inputs();
    wait_until(e0 + 8);
    chk("t2_empty", 32'(bif.empty_o), 32'h1);

    // Seven d=20 pushes: one loaded + four queued, last two rejected
    for (int i = 0; i < 7; i++) begin
      set_push(7'd20, 16'h0100 + 16'(i));
      step();
      if (i == 0) e0 = cyc;
      if (i < 5) expect_stb(e0 + 22 + 21 * i, 16'h0100 + 16'(i));
      if (i == 4) begin
        chk("t3_full", 32'(bif.full_o), 32'h1);
        chk("t3_level4", 32'(bif.level_o), 32'h4);
        chk("t3_no_err", 32'(bif.err_o), 32'h0);
      end
      if (i >= 5) begin
        chk("t3_err_pulse", 32'(bif.err_o), 32'h1);
        chk("t3_ovf_step", 32'(bif.ovf_cnt_o), 32'(i - 4));
      end
    end
    idle_inputs();
    step();
    chk("t3_err_clear", 32'(bif.err_o), 32'h0);
    chk("t3_ovf", 32'(bif.ovf_cnt_o), 32'h2);
    wait_until(e0 + 23);
    chk("t3_level_after_pop", 32'(bif.level_o), 32'h3);
    chk("t3_full_clear", 32'(bif.full_o), 32'h0);
    wait_until(e0 + 110);
    chk("t3_empty", 32'(bif.empty_o), 32'h1);

    // Direct collides with due word: direct first, queued word next edge
    set_push(7'd2, 16'h0001);
    step();
    e0 = cyc;
    idle_inputs();
    wait_until(e0 + 3);
    bif.direct_i = 1'b1;
    bif.data_i   = 16'hBEEF;
    expect_stb(e0 + 4, 16'hBEEF);
    expect_stb(e0 + 5, 16'h0001);
    step();
    idle_inputs();
    wait_until(e0 + 7);

    // Pause 5 cycles mid-countdown of d=4: strobe moves from +6 to +11
    set_push(7'd4, 16'h5555);
    step();
    e0 = cyc;
    idle_inputs();
    expect_stb(e0 + 11, 16'h5555);
    wait_until(e0 + 2);
    bif.pause_i = 1'b1;
    repeat (5) step();
    bif.pause_i = 1'b0;
    wait_until(e0 + 13);

    // Flush mid-countdown, with a simultaneous push that must vanish silently
    set_push(7'd6, 16'h7777);
    step();
    idle_inputs();
    step();
    bif.flush_i = 1'b1;
    set_push(7'd1, 16'h9999);
    step();
    idle_inputs();
    chk("t5_flush_empty", 32'(bif.empty_o), 32'h1);
    chk("t5_flush_level", 32'(bif.level_o), 32'h0);
    chk("t5_flush_no_err", 32'(bif.err_o), 32'h0);
    chk("t5_flush_hold", 32'(bif.data_o), 32'h5555);
    repeat (12) step();
    chk("t5_still_empty", 32'(bif.empty_o), 32'h1);

    // Async reset between edges with three words in flight
    for (int i = 0; i < 3; i++) begin
      set_push(7'd10, 16'h0011 * 16'(i + 1));
      step();
    end
    idle_inputs();
    repeat (2) step();
    chk("t6_level_pre", 32'(bif.level_o), 32'h2);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_data", 32'(bif.data_o), 32'h0);
    chk("t6_empty", 32'(bif.empty_o), 32'h1);
    chk("t6_level", 32'(bif.level_o), 32'h0);
    chk("t6_ovf", 32'(bif.ovf_cnt_o), 32'h0);
    repeat (2) step();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) step();
    chk("t6_empty_after", 32'(bif.empty_o), 32'h1);

    chk("sb_drained", 32'(exp_edge.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
